// File: rtl/rotating_shift_buffer.sv
// rotating_shift_buffer: loads BUFFER_SIZE elements in parallel, then emits
// num_beats views of the bank. Each accepted beat rotates the bank by STRIDE
// in the direction latched at load time.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. The producer holds its payload while valid is high and
// ready is low, and ready never waits on valid from the same side. Input
// side: data_in_valid/data_in_ready. Output side: data_out_valid/data_out_ready.
module rotating_shift_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int BUFFER_SIZE = 16,
    parameter int STRIDE      = 1,
    localparam int BEAT_W     = $clog2(BUFFER_SIZE) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [BUFFER_SIZE],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    input  logic                  rotate_left,
    input  logic [BEAT_W-1:0]     num_beats,
    output logic [DATA_WIDTH-1:0] data_out [BUFFER_SIZE],
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  data_out_last,
    output logic [BEAT_W-1:0]     beat_index,
    output logic                  state_dbg
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] bank_q [BUFFER_SIZE];
    logic [DATA_WIDTH-1:0] bank_d [BUFFER_SIZE];
    logic [DATA_WIDTH-1:0] rot_l  [BUFFER_SIZE];
    logic [DATA_WIDTH-1:0] rot_r  [BUFFER_SIZE];
    logic                  dir_q, dir_d;
    logic [BEAT_W-1:0]     total_q, total_d;
    logic [BEAT_W-1:0]     cnt_q, cnt_d;
    logic                  last;

    // Fixed-stride rotations are pure wiring; indices resolve at elaboration.
    for (genvar g = 0; g < BUFFER_SIZE; g++) begin : g_rot
        localparam int LI = (g + STRIDE) % BUFFER_SIZE;
        localparam int RI = (g + BUFFER_SIZE - STRIDE) % BUFFER_SIZE;
        assign rot_l[g] = bank_q[LI];
        assign rot_r[g] = bank_q[RI];
    end

    assign last           = (state_q == ACTIVE) && (cnt_q == total_q - BEAT_W'(1));
    assign data_in_ready  = (state_q == IDLE);
    assign data_out_valid = (state_q == ACTIVE);
    assign data_out_last  = last;
    assign beat_index     = cnt_q;
    assign data_out       = bank_q;
    assign state_dbg      = state_q;

    // Next-state: load in IDLE, advance/rotate or finish on an output handshake.
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        dir_d   = dir_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (data_in_valid) begin
                    bank_d  = data_in;
                    dir_d   = rotate_left;
                    // A zero beat request still produces one beat.
                    total_d = (num_beats == '0) ? BEAT_W'(1) : num_beats;
                    cnt_d   = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (data_out_ready) begin
                    if (last) begin
                        // The final view stays visible in IDLE; no rotation here.
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d  = cnt_q + BEAT_W'(1);
                        bank_d = dir_q ? rot_l : rot_r;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < BUFFER_SIZE; i++) bank_q[i] <= '0;
            dir_q   <= 1'b0;
            total_q <= BEAT_W'(1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            dir_q   <= dir_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/rotating_shift_buffer.md
ROTATING_SHIFT_BUFFER -- requirements
Module: rotating_shift_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bit width of one element.
REQ-002 SHALL have parameter BUFFER_SIZE, default 16, element count N; legal range 2..256.
REQ-003 SHALL have parameter STRIDE, default 1, elements rotated per output beat; legal range 1..BUFFER_SIZE-1.
REQ-004 SHALL define localparam BEAT_W = $clog2(BUFFER_SIZE)+1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 data_in  input  DATA_WIDTH x BUFFER_SIZE (unpacked array)  parallel load vector.
REQ-008 data_in_valid  input  1  load request.
REQ-009 data_in_ready  output  1  load accepted when high with data_in_valid.
REQ-010 rotate_left  input  1  direction sampled at load; 1 = left, 0 = right.
REQ-011 num_beats  input  BEAT_W  output beats for this load, sampled at load.
REQ-012 data_out  output  DATA_WIDTH x BUFFER_SIZE (unpacked array)  current buffer view.
REQ-013 data_out_valid  output  1  data_out holds a beat.
REQ-014 data_out_ready  input  1  consumer accepts beat.
REQ-015 data_out_last  output  1  current beat is final beat of this load.
REQ-016 beat_index  output  BEAT_W  zero-based index of current beat.

Function
REQ-017 SHALL implement two states, IDLE and ACTIVE, plus register bank, latched direction, latched beat count, and beat counter.
REQ-018 data_in_ready SHALL be 1 exactly when state is IDLE; data_out_valid SHALL be 1 exactly when state is ACTIVE.
REQ-019 In IDLE with data_in_valid=1: on the edge, bank <= data_in, direction <= rotate_left, beat count <= max(num_beats,1), beat counter <= 0, state <= ACTIVE.
REQ-020 Load-to-first-output latency SHALL be 1 cycle: data_out_valid rises the cycle after the load handshake.
REQ-021 data_out SHALL be driven directly from the bank in every state.
REQ-022 beat_index SHALL equal the beat counter; data_out_last SHALL be 1 iff ACTIVE and counter == beat count - 1.
REQ-023 In ACTIVE with data_out_valid=1 and data_out_ready=0, bank, counter and state SHALL hold, so data_out stays stable.
REQ-024 On an output handshake with data_out_last=0: counter += 1; bank rotates by STRIDE.
REQ-025 Left rotation: new bank[i] = old bank[(i+STRIDE) mod N].
REQ-026 Right rotation: new bank[i] = old bank[(i-STRIDE) mod N].
REQ-027 On an output handshake with data_out_last=1: state <= IDLE; bank not rotated; counter <= 0.
REQ-028 num_beats SHALL be allowed to exceed N; rotation wraps modulo N with no special case.
REQ-029 num_beats = 0 SHALL be treated as 1 beat.
REQ-030 No load SHALL be accepted in ACTIVE; data_in_valid there is ignored, and a new load is first possible the cycle after the last beat's handshake.
REQ-031 data_in, rotate_left and num_beats SHALL be sampled only on the load handshake edge.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for clk, set state IDLE, every bank element 0, beat counter 0, latched beat count 1, direction 0.
REQ-033 Outputs during and after reset: data_in_ready=1, data_out_valid=0, data_out_last=0, beat_index=0, data_out all zero.
REQ-034 Reset asserted mid-ACTIVE SHALL abort the sequence; no further beats from that load.

Verification
REQ-035 N=4, W=8, STRIDE=1, load {A,B,C,D} (element 0 first), left, num_beats=4, ready held 1 -> beats ABCD, BCDA, CDAB, DABC; last only on beat 3; data_in_ready=1 the next cycle.
REQ-036 Same load, right, num_beats=3 -> ABCD, DABC, CDAB; last on beat 2.
REQ-037 STRIDE=2, left, num_beats=6 -> ABCD, CDAB, ABCD, CDAB, ABCD, CDAB; beat_index 0..5.
REQ-038 Backpressure: ready low 3 cycles on beat 1 -> BCDA held stable, beat_index=1 held, valid stays 1; sequence resumes unchanged.
REQ-039 num_beats=0 -> exactly one beat ABCD with last=1; data_in_valid pulsed during ACTIVE is not accepted.
REQ-040 Assert rst between clock edges during beat 2 -> outputs reach reset values before the next edge; a subsequent load starts at beat_index 0.
